// File: rtl/issue_entry_releaser8.sv
// Issue/release side of an 8-entry issue queue: per-entry state, wakeup, 2-wide select, FU handshake.
// Optional ISSUE_OLDEST_FIRST_EN: age-matrix oldest-first selection instead of lowest-index priority.
module issue_entry_releaser8 #(
    parameter  int unsigned IO_ID_WIDTH = 3,
    localparam int unsigned NUM_ENTRY   = 2 ** IO_ID_WIDTH,
    localparam int unsigned OCC_W       = IO_ID_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alloc_valid_0,
    input  logic [IO_ID_WIDTH-1:0] alloc_id_0,
    input  logic                   alloc_rdy_0,
    input  logic                   alloc_valid_1,
    input  logic [IO_ID_WIDTH-1:0] alloc_id_1,
    input  logic                   alloc_rdy_1,
    input  logic [NUM_ENTRY-1:0]   wakeup_vec,
    output logic                   issue_valid_0,
    output logic [IO_ID_WIDTH-1:0] issue_id_0,
    input  logic                   issue_ready_0,
    output logic                   issue_valid_1,
    output logic [IO_ID_WIDTH-1:0] issue_id_1,
    input  logic                   issue_ready_1,
    output logic [NUM_ENTRY-1:0]   entry_free,
    output logic [OCC_W-1:0]       occupancy
);

    localparam int unsigned PICK_W = IO_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } entry_state_e;

    entry_state_e           state_q [NUM_ENTRY];
    entry_state_e           state_d [NUM_ENTRY];
    logic [1:0]             slot_valid_q;
    logic [1:0]             slot_valid_d;
    logic [IO_ID_WIDTH-1:0] slot_id_q [2];
    logic [IO_ID_WIDTH-1:0] slot_id_d [2];
    logic [NUM_ENTRY-1:0]   entry_free_q;
    logic [NUM_ENTRY-1:0]   entry_free_d;
    logic [OCC_W-1:0]       occ_q;
    logic [OCC_W-1:0]       occ_d;

    logic [1:0]             hs;
    logic [1:0]             loadable;
    logic                   alloc_ok_0;
    logic                   alloc_ok_1;
    logic [NUM_ENTRY-1:0]   cand;
    logic [NUM_ENTRY-1:0]   cand_rest;
    logic [PICK_W-1:0]      pick_a;
    logic [PICK_W-1:0]      pick_b;
    logic [PICK_W-1:0]      sel [2];

`ifdef ISSUE_OLDEST_FIRST_EN
    // older_q[i][j] = 1: entry j was allocated before entry i
    logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] older_q;
    logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] older_d;

    function automatic logic [PICK_W-1:0] pick_oldest(
        input logic [NUM_ENTRY-1:0]                mask,
        input logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] older
    );
        logic [PICK_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (mask[i] && ((mask & older[i]) == '0)) r = {1'b1, IO_ID_WIDTH'(i)};
        end
        return r;
    endfunction
`else
    function automatic logic [PICK_W-1:0] pick_lowest(input logic [NUM_ENTRY-1:0] mask);
        logic [PICK_W-1:0] r;
        r = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (mask[i]) r = {1'b1, IO_ID_WIDTH'(i)};
        end
        return r;
    endfunction
`endif

    // Candidate selection on current-cycle READY entries
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            cand[i] = (state_q[i] == ST_READY);
        end
`ifdef ISSUE_OLDEST_FIRST_EN
        pick_a = pick_oldest(cand, older_q);
`else
        pick_a = pick_lowest(cand);
`endif
        cand_rest = cand;
        if (pick_a[PICK_W-1]) cand_rest[pick_a[IO_ID_WIDTH-1:0]] = 1'b0;
`ifdef ISSUE_OLDEST_FIRST_EN
        pick_b = pick_oldest(cand_rest, older_q);
`else
        pick_b = pick_lowest(cand_rest);
`endif
    end

    // Entry state / issue slot next-state
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            state_d[i] = state_q[i];
        end
        slot_valid_d = slot_valid_q;
        slot_id_d[0] = slot_id_q[0];
        slot_id_d[1] = slot_id_q[1];
        entry_free_d = '0;
        occ_d        = '0;

        hs         = slot_valid_q & {issue_ready_1, issue_ready_0};
        loadable   = ~slot_valid_q | hs;
        alloc_ok_0 = alloc_valid_0 && (state_q[alloc_id_0] == ST_FREE);
        alloc_ok_1 = alloc_valid_1 && (state_q[alloc_id_1] == ST_FREE) &&
                     !(alloc_valid_0 && (alloc_id_0 == alloc_id_1));
        sel[0]     = pick_a;
        sel[1]     = loadable[0] ? pick_b : pick_a;

        for (int k = 0; k < 2; k++) begin
            if (hs[k]) state_d[slot_id_q[k]] = ST_FREE;
        end

        for (int i = 0; i < NUM_ENTRY; i++) begin
            if ((state_q[i] == ST_WAIT) && wakeup_vec[i]) state_d[i] = ST_READY;
        end

        if (alloc_ok_0) begin
            state_d[alloc_id_0] = (alloc_rdy_0 || wakeup_vec[alloc_id_0]) ? ST_READY : ST_WAIT;
        end
        if (alloc_ok_1) begin
            state_d[alloc_id_1] = (alloc_rdy_1 || wakeup_vec[alloc_id_1]) ? ST_READY : ST_WAIT;
        end

        for (int k = 0; k < 2; k++) begin
            if (loadable[k]) begin
                slot_valid_d[k] = sel[k][PICK_W-1];
                if (sel[k][PICK_W-1]) begin
                    slot_id_d[k]                         = sel[k][IO_ID_WIDTH-1:0];
                    state_d[sel[k][IO_ID_WIDTH-1:0]] = ST_ISSUED;
                end
            end
        end

        if (flush) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                state_d[i] = ST_FREE;
            end
            slot_valid_d = '0;
        end

        for (int i = 0; i < NUM_ENTRY; i++) begin
            entry_free_d[i] = (state_d[i] == ST_FREE);
            occ_d           = occ_d + OCC_W'(!entry_free_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                state_q[i] <= ST_FREE;
            end
            slot_valid_q <= '0;
            slot_id_q[0] <= '0;
            slot_id_q[1] <= '0;
            entry_free_q <= '1;
            occ_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                state_q[i] <= state_d[i];
            end
            slot_valid_q <= slot_valid_d;
            slot_id_q[0] <= slot_id_d[0];
            slot_id_q[1] <= slot_id_d[1];
            entry_free_q <= entry_free_d;
            occ_q        <= occ_d;
        end
    end

`ifdef ISSUE_OLDEST_FIRST_EN
    // A new entry is younger than everything; alloc_0 is applied first so it is older than alloc_1
    always_comb begin
        older_d = older_q;
        if (!flush && alloc_ok_0) begin
            for (int j = 0; j < NUM_ENTRY; j++) begin
                older_d[j][alloc_id_0] = 1'b0;
            end
            older_d[alloc_id_0] = ~(NUM_ENTRY'(1) << alloc_id_0);
        end
        if (!flush && alloc_ok_1) begin
            for (int j = 0; j < NUM_ENTRY; j++) begin
                older_d[j][alloc_id_1] = 1'b0;
            end
            older_d[alloc_id_1] = ~(NUM_ENTRY'(1) << alloc_id_1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`endif

    assign issue_valid_0 = slot_valid_q[0];
    assign issue_valid_1 = slot_valid_q[1];
    assign issue_id_0    = slot_id_q[0];
    assign issue_id_1    = slot_id_q[1];
    assign entry_free    = entry_free_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_issue_entry_releaser8.sv
// Directed, table-driven bench for issue_entry_releaser8, plus an asynchronous-reset sequence.
module tb_issue_entry_releaser8;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       alloc_valid_0, alloc_rdy_0, alloc_valid_1, alloc_rdy_1;
    logic [2:0] alloc_id_0, alloc_id_1;
    logic [7:0] wakeup_vec;
    logic       issue_valid_0, issue_valid_1, issue_ready_0, issue_ready_1;
    logic [2:0] issue_id_0, issue_id_1;
    logic [7:0] entry_free;
    logic [3:0] occupancy;

    issue_entry_releaser8 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .alloc_valid_0 (alloc_valid_0),
        .alloc_id_0    (alloc_id_0),
        .alloc_rdy_0   (alloc_rdy_0),
        .alloc_valid_1 (alloc_valid_1),
        .alloc_id_1    (alloc_id_1),
        .alloc_rdy_1   (alloc_rdy_1),
        .wakeup_vec    (wakeup_vec),
        .issue_valid_0 (issue_valid_0),
        .issue_id_0    (issue_id_0),
        .issue_ready_0 (issue_ready_0),
        .issue_valid_1 (issue_valid_1),
        .issue_id_1    (issue_id_1),
        .issue_ready_1 (issue_ready_1),
        .entry_free    (entry_free),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ISSUE_OLDEST_FIRST_EN
    localparam logic [2:0] A0 = 3'd5;
    localparam logic [2:0] A1 = 3'd2;
`else
    localparam logic [2:0] A0 = 3'd2;
    localparam logic [2:0] A1 = 3'd5;
`endif

    typedef struct {
        logic       fl;
        logic       av0;
        logic [2:0] aid0;
        logic       ar0;
        logic       av1;
        logic [2:0] aid1;
        logic       ar1;
        logic [7:0] wake;
        logic       ir0;
        logic       ir1;
        logic       eiv0;
        logic [2:0] eid0;
        logic       eiv1;
        logic [2:0] eid1;
        logic [7:0] efree;
        logic [3:0] eocc;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic av0, input logic [2:0] aid0, input logic ar0,
                       input logic av1, input logic [2:0] aid1, input logic ar1,
                       input logic [7:0] wake, input logic ir0, input logic ir1,
                       input logic eiv0, input logic [2:0] eid0, input logic eiv1,
                       input logic [2:0] eid1, input logic [7:0] efree, input logic [3:0] eocc);
        vec_t v;
        v.fl = fl; v.av0 = av0; v.aid0 = aid0; v.ar0 = ar0;
        v.av1 = av1; v.aid1 = aid1; v.ar1 = ar1; v.wake = wake;
        v.ir0 = ir0; v.ir1 = ir1; v.eiv0 = eiv0; v.eid0 = eid0;
        v.eiv1 = eiv1; v.eid1 = eid1; v.efree = efree; v.eocc = eocc;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_valid_0 = 0; alloc_id_0 = 0; alloc_rdy_0 = 0;
        alloc_valid_1 = 0; alloc_id_1 = 0; alloc_rdy_1 = 0; wakeup_vec = 0;
        issue_ready_0 = 0; issue_ready_1 = 0;
    endtask

    task automatic check_outputs(input string tag, input logic eiv0, input logic [2:0] eid0,
                                 input logic eiv1, input logic [2:0] eid1,
                                 input logic [7:0] efree, input logic [3:0] eocc);
        chk({tag, "_iv0"}, 8'(issue_valid_0), 8'(eiv0));
        chk({tag, "_iv1"}, 8'(issue_valid_1), 8'(eiv1));
        if (eiv0) chk({tag, "_id0"}, 8'(issue_id_0), 8'(eid0));
        if (eiv1) chk({tag, "_id1"}, 8'(issue_id_1), 8'(eid1));
        chk({tag, "_free"}, entry_free, efree);
        chk({tag, "_occ"}, 8'(occupancy), 8'(eocc));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();

        //   fl av0 id0 r0 av1 id1 r1 wake  ir0 ir1 | iv0 id0 iv1 id1 free  occ
        add(0, 1, 5, 1, 1, 2, 1, 8'h00, 1, 1,  0, 0, 0, 0,  8'hDB, 2);  // two allocs, ready
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  1, A0, 1, A1, 8'hDB, 2); // priority order
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);  // both accepted
        add(0, 1, 3, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hF7, 1);  // alloc waiting
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hF7, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0,  0, 0, 0, 0,  8'hF7, 1);  // wakeup edge
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 3, 0, 0,  8'hF7, 1);  // issued one edge later
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 0,  8'hFF, 0);
        add(0, 1, 1, 1, 0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0,  8'hFD, 1);  // stall sequence
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 0, 0,  8'hFD, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 0, 0,  8'hFD, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 0, 0,  8'hFD, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 0, 0,  8'hFD, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 0, 0,  8'hFD, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 0,  8'hFF, 0);  // accept after stall
        add(0, 1, 0, 0, 1, 1, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFC, 2);  // fill all eight
        add(0, 1, 2, 0, 1, 3, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hF0, 4);
        add(0, 1, 4, 0, 1, 5, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hC0, 6);
        add(0, 1, 6, 0, 1, 7, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'h00, 8);
        add(1, 1, 0, 1, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);  // flush beats alloc
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);
        add(0, 1, 4, 0, 1, 4, 1, 8'h00, 1, 1,  0, 0, 0, 0,  8'hEF, 1);  // same id: port 0 wins
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hEF, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h10, 1, 1,  0, 0, 0, 0,  8'hEF, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  1, 4, 0, 0,  8'hEF, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);
        add(0, 1, 6, 0, 0, 0, 0, 8'h40, 1, 1,  0, 0, 0, 0,  8'hBF, 1);  // alloc + wakeup same id
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  1, 6, 0, 0,  8'hBF, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);
        add(0, 1, 1, 1, 1, 2, 1, 8'h00, 0, 0,  0, 0, 0, 0,  8'hF9, 2);  // one-slot reload
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1,  1, 1, 1, 2,  8'hF9, 2);
        add(0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1,  1, 1, 0, 0,  8'hFC, 2);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 1, 0,  8'hFC, 2);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 0,  8'hFF, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset", 0, 0, 0, 0, 8'hFF, 4'd0);
        chk("reset_id0", 8'(issue_id_0), 8'h00);
        chk("reset_id1", 8'(issue_id_1), 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            flush         = vecs[i].fl;
            alloc_valid_0 = vecs[i].av0;
            alloc_id_0    = vecs[i].aid0;
            alloc_rdy_0   = vecs[i].ar0;
            alloc_valid_1 = vecs[i].av1;
            alloc_id_1    = vecs[i].aid1;
            alloc_rdy_1   = vecs[i].ar1;
            wakeup_vec    = vecs[i].wake;
            issue_ready_0 = vecs[i].ir0;
            issue_ready_1 = vecs[i].ir1;
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i + 1), vecs[i].eiv0, vecs[i].eid0,
                          vecs[i].eiv1, vecs[i].eid1, vecs[i].efree, vecs[i].eocc);
        end

        // Asynchronous reset between edges while both ports hold entries
        @(negedge clk);
        idle_inputs();
        alloc_valid_0 = 1; alloc_id_0 = 3'd0; alloc_rdy_0 = 1;
        alloc_valid_1 = 1; alloc_id_1 = 3'd1; alloc_rdy_1 = 1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check_outputs("pre_rst", 1, 3'd0, 1, 3'd1, 8'hFC, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0, 8'hFF, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 0, 0, 0, 0, 8'hFF, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
